// File: rtl/netlist_resp_capture.sv
// -----------------------------------------------------------------------------
// netlist_resp_capture
//
// Purpose:
//   This is the response-side capture block for vector-driven netlist benches.
//   Each accepted WIDTH-bit output word is folded into a MISR signature.
//   Each word is also XORed with the previously accepted word. The popcount of
//   that XOR is a per-vector switching-activity figure. These figures are
//   accumulated as a saturating total and a running maximum.
//   After VEC_COUNT words, the block drains its two-stage toggle pipeline and
//   then reports done.
//
// Optional feature (macro NETLIST_RESP_COMPARE_EN):
//   Adds an expected-data input and per-run mismatch bookkeeping:
//   a saturating mismatch count, the index of the first failing vector and a
//   sticky fail flag.
//   With the macro undefined, those ports and that logic are absent.
//
// Ports:
//   clk            in   rising-edge clock
//   rst            in   asynchronous active-low reset
//   start          in   one-cycle pulse; starts a run from IDLE or DONE
//   resp_valid     in   resp_data is valid
//   resp_data      in   [WIDTH] DUT output word
//   exp_data       in   [WIDTH] expected word            (compare build only)
//   mismatch_cnt   out  [CNT_W] saturating mismatches   (compare build only)
//   first_fail_idx out  [CNT_W] index of first mismatch (compare build only)
//   fail           out  sticky mismatch flag            (compare build only)
//   resp_ready     out  high only in CAPTURE
//   busy           out  high in CAPTURE or DRAIN
//   done           out  run complete; held until next start
//   signature      out  [WIDTH] MISR value
//   vec_count      out  [CNT_W] words accepted this run
//   toggle_total   out  [CNT_W] saturating sum of per-vector toggles
//   toggle_max     out  [TOG_W] largest per-vector toggle count
// -----------------------------------------------------------------------------
module netlist_resp_capture #(
   parameter int                WIDTH     = 62,
   parameter int                VEC_COUNT = 1000,
   parameter int                CNT_W     = 32,
   parameter logic [WIDTH-1:0]  MISR_POLY = WIDTH'(62'h0000_0000_0000_0043),
   parameter int                TOG_W     = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             resp_valid,
   input  logic [WIDTH-1:0] resp_data,
`ifdef NETLIST_RESP_COMPARE_EN
   input  logic [WIDTH-1:0] exp_data,
   output logic [CNT_W-1:0] mismatch_cnt,
   output logic [CNT_W-1:0] first_fail_idx,
   output logic             fail,
`endif
   output logic             resp_ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] signature,
   output logic [CNT_W-1:0] vec_count,
   output logic [CNT_W-1:0] toggle_total,
   output logic [TOG_W-1:0] toggle_max
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_CAPTURE = 2'd1,
      S_DRAIN   = 2'd2,
      S_DONE    = 2'd3
   } state_t;

   state_t           r_state;
   state_t           w_next_state;
   logic             r_drain_cnt;

   logic [WIDTH-1:0] r_signature;
   logic [CNT_W-1:0] r_vec_count;
   logic [WIDTH-1:0] r_prev_word;
   logic [WIDTH-1:0] r_diff_q;
   logic             r_d_v;
   logic [CNT_W-1:0] r_toggle_total;
   logic [TOG_W-1:0] r_toggle_max;

   logic             w_start_run;
   logic             w_accept;
   logic             w_last;
   logic [WIDTH-1:0] w_sig_next;
   logic [TOG_W-1:0] w_pop;
   logic [CNT_W:0]   w_tot_sum;
   logic [CNT_W-1:0] w_tot_next;

   function automatic logic [TOG_W-1:0] popcount(input logic [WIDTH-1:0] v);
      logic [TOG_W-1:0] cnt;
      cnt = '0;
      for (int i = 0; i < WIDTH; i++) begin
         cnt = cnt + TOG_W'(v[i]);
      end
      return cnt;
   endfunction

   // A start pulse only acts when no run is in flight.
   // Starts seen in CAPTURE or DRAIN fall through unused.
   assign w_start_run = start & ((r_state == S_IDLE) | (r_state == S_DONE));
   assign w_accept    = resp_valid & (r_state == S_CAPTURE);
   assign w_last      = (r_vec_count == CNT_W'(VEC_COUNT - 1));

   // MISR step: shift left, fold the escaping MSB back through the taps,
   // then inject the new word.
   assign w_sig_next  = {r_signature[WIDTH-2:0], 1'b0}
                      ^ (r_signature[WIDTH-1] ? MISR_POLY : '0)
                      ^ resp_data;

   // The adder is one bit wider than the total, so the carry out flags
   // overflow and the total saturates at all-ones.
   assign w_pop       = popcount(r_diff_q);
   assign w_tot_sum   = {1'b0, r_toggle_total} + (CNT_W + 1)'(w_pop);
   assign w_tot_next  = w_tot_sum[CNT_W] ? '1 : w_tot_sum[CNT_W-1:0];

   // ---------------------------------------------------------------- FSM
   // NOTE: state registers use non-blocking assignments, so every flop
   // samples pre-edge values and the order of always_ff blocks is irrelevant.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // NOTE: w_next_state is defaulted before the case statement, so paths
   // that do not assign it cannot infer a latch.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:    if (start) w_next_state = S_CAPTURE;
         S_CAPTURE: if (w_accept && w_last) w_next_state = S_DRAIN;
         S_DRAIN:   if (r_drain_cnt) w_next_state = S_DONE;
         S_DONE:    if (start) w_next_state = S_CAPTURE;
         default:   w_next_state = S_IDLE;
      endcase
   end

   // DRAIN holds for two cycles. That covers the stage-2 update of the last
   // vector, and done rises two edges after the final accept.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_drain_cnt <= 1'b0;
      end else begin
         r_drain_cnt <= (r_state == S_DRAIN);
      end
   end

   // ----------------------------------------------------------- datapath
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_signature    <= '0;
         r_vec_count    <= '0;
         r_prev_word    <= '0;
         r_diff_q       <= '0;
         r_d_v          <= 1'b0;
         r_toggle_total <= '0;
         r_toggle_max   <= '0;
      end else if (w_start_run) begin
         r_signature    <= '0;
         r_vec_count    <= '0;
         r_prev_word    <= '0;
         r_diff_q       <= '0;
         r_d_v          <= 1'b0;
         r_toggle_total <= '0;
         r_toggle_max   <= '0;
      end else begin
         // Stage 1: capture the word, advance the MISR and compute its
         // difference from the previous word.
         // The first word of a run is compared against zero.
         if (w_accept) begin
            r_signature <= w_sig_next;
            r_vec_count <= r_vec_count + 1'b1;
            r_prev_word <= resp_data;
            r_diff_q    <= resp_data ^ r_prev_word;
            r_d_v       <= 1'b1;
         end else begin
            r_d_v       <= 1'b0;
         end

         // Stage 2: accumulate the popcount of the registered difference.
         if (r_d_v) begin
            r_toggle_total <= w_tot_next;
            if (w_pop > r_toggle_max) begin
               r_toggle_max <= w_pop;
            end
         end
      end
   end

`ifdef NETLIST_RESP_COMPARE_EN
   // ------------------------------------------------------ compare option
   logic [CNT_W-1:0] r_mismatch_cnt;
   logic [CNT_W-1:0] r_first_fail_idx;
   logic             r_fail;
   logic             w_miss;

   assign w_miss = w_accept & (resp_data != exp_data);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_mismatch_cnt   <= '0;
         r_first_fail_idx <= '0;
         r_fail           <= 1'b0;
      end else if (w_start_run) begin
         r_mismatch_cnt   <= '0;
         r_first_fail_idx <= '0;
         r_fail           <= 1'b0;
      end else if (w_miss) begin
         if (r_mismatch_cnt != '1) begin
            r_mismatch_cnt <= r_mismatch_cnt + 1'b1;
         end
         // r_vec_count still holds the pre-increment, 0-based index of
         // the word that is being accepted.
         if (!r_fail) begin
            r_first_fail_idx <= r_vec_count;
            r_fail           <= 1'b1;
         end
      end
   end

   assign mismatch_cnt   = r_mismatch_cnt;
   assign first_fail_idx = r_first_fail_idx;
   assign fail           = r_fail;
`endif

   // ------------------------------------------------------------ outputs
   assign resp_ready   = (r_state == S_CAPTURE);
   assign busy         = (r_state == S_CAPTURE) | (r_state == S_DRAIN);
   assign done         = (r_state == S_DONE);
   assign signature    = r_signature;
   assign vec_count    = r_vec_count;
   assign toggle_total = r_toggle_total;
   assign toggle_max   = r_toggle_max;

endmodule

// File: doc/netlist_resp_capture.md
Name: netlist_resp_capture

Overview:
- Response-side partner of the vector-driven netlist benches.
- Accepts one WIDTH-bit output word per handshake from the DUT netlist and compacts the run into a MISR signature.
- Accumulates per-vector Hamming toggle counts as a switching-activity proxy for power runs.
- Counts accepted vectors and flags completion after VEC_COUNT words.

Parameters:
WIDTH, 62, response word width (DUT output count)
VEC_COUNT, 1000, vectors per run
CNT_W, 32, width of vector/toggle counters
MISR_POLY, 62'h0000_0000_0000_0043, feedback taps XORed when signature MSB shifts out
TOG_W, $clog2(WIDTH+1), width of per-vector toggle value

Ports:
clk  in  1  clock; all state on rising edge
rst  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a run from IDLE or DONE
resp_valid  in  1  resp_data valid
resp_data  in  WIDTH  DUT output word
resp_ready  out  1  block can accept a word
busy  out  1  high in CAPTURE or DRAIN
done  out  1  run complete; held until next start
signature  out  WIDTH  MISR value
vec_count  out  CNT_W  accepted words this run
toggle_total  out  CNT_W  sum of per-vector toggles, saturating
toggle_max  out  TOG_W  largest single-vector toggle count

Behaviour:
- Reset (rst=0, async): state IDLE.
  - All outputs 0.
  - prev_word 0, pipeline valid flags 0.
- FSM states: IDLE, CAPTURE, DRAIN, DONE.
- IDLE/DONE + start -> CAPTURE.
  - Clears signature, vec_count, toggle_total, toggle_max, prev_word, done, pipeline.
- resp_ready = (state==CAPTURE). Accept = resp_valid & resp_ready.
- On accept, all in the same edge:
  - signature <= {sig[WIDTH-2:0],0} ^ (sig[WIDTH-1] ? MISR_POLY : 0) ^ resp_data.
  - vec_count += 1.
  - prev_word <= resp_data.
  - Stage-1 diff_q <= resp_data ^ prev_word; d_v <= 1.
  - Without an accept, d_v <= 0.
- Stage 2: when d_v=1, at the next edge:
  - toggle_total += popcount(diff_q), saturating at 2^CNT_W-1.
  - toggle_max <= max(toggle_max, popcount).
- First vector of a run toggles against all-zero.
- Accept with vec_count==VEC_COUNT-1 -> DRAIN.
  - DRAIN lasts exactly 2 cycles so stage 2 completes; then DONE, done=1.
  - done is visible 2 clocks after the final accepting edge.
- resp_valid with resp_ready=0: word ignored, no side effects. Not an error.
- start in CAPTURE/DRAIN: ignored.
- start and resp_valid in the same cycle in IDLE: only start acts; the word is not accepted.
- Gaps (resp_valid low) in CAPTURE: counters hold; the pipeline bubble is harmless.
- Reset mid-run: immediate return to IDLE with everything cleared. No partial results retained.

Optional Feature:
- Macro: NETLIST_RESP_COMPARE_EN.
- With the macro defined, these ports are added:
  - exp_data in WIDTH
  - mismatch_cnt out CNT_W
  - first_fail_idx out CNT_W
  - fail out 1
- Compare behaviour:
  - On each accept, resp_data != exp_data increments mismatch_cnt (saturating).
  - On the first mismatch of a run, first_fail_idx <= current vec_count (0-based) and fail <= 1.
  - All three clear on start and reset.
- Without the macro: ports absent, no compare logic; core behaviour identical.

Test Plan:
- Reset: rst low mid-CAPTURE after 3 accepts -> all outputs 0 immediately (async), resp_ready=0; release, start -> clean run.
- Toggle accounting (VEC_COUNT=4): words all-ones (62'h3FFF_FFFF_FFFF_FFFF), 0, all-ones, 0, back-to-back -> toggle_total=248, toggle_max=62, vec_count=4, done high 2 cycles after 4th accept.
- MISR (VEC_COUNT=2): D1=62'h2000_0000_0000_0001, D2=62'h1 -> signature = 62'h2 ^ 62'h43 ^ 62'h1 = 62'h40.
- Backpressure/gaps: resp_valid toggled randomly during CAPTURE, then resp_valid held high in DONE -> only VEC_COUNT words counted; extra words ignored, signature unchanged.
- Restart: start in DONE -> counters cleared, done=0; start while busy -> ignored, vec_count unaffected.
- Compare (macro defined, VEC_COUNT=5): exp_data equals resp_data except at index 2 and 4 -> mismatch_cnt=2, first_fail_idx=2, fail=1.
